mac_tx_ctrl: RTL and testbench

Transmit sequencer for the 10G MAC TX path: a state machine that drives the generate-select inputs of the XGMII frame generator (`mac_tx_framegen`) and the read side of the TX frame buffer. It emits the header words, streams buffered frame words, enforces the minimum inter-frame gap, and on buffer underrun emits an error word and flushes the broken frame. It sits between the TX frame buffer (first-word-fall-through) and `mac_tx_framegen`.

---
 rtl/mac_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mac_tx_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_ctrl.sv
// Purpose: TX sequencer driving mac_tx_framegen selects and the TX frame buffer read side.
// Latency: HDR index 0 is driven the cycle after a start decision; selects are combinational from state.
// Backpressure: i_clk_en freezes state/counters and masks o_buf_ren; an empty buffer mid-frame is an underrun.
//
// Ports:
//   i_clk, i_reset_n (sync, active-low), i_clk_en
//   i_tx_en, i_frame_avail                    - frame start qualifiers
//   i_buf_empty, i_buf_rlast, o_buf_ren       - FWFT buffer head / pop
//   o_gen_hdr/o_hdr_id/o_gen_data/o_gen_error/o_gen_idle/o_gen_ifg - framegen selects
//   o_frame_start, o_busy                     - status
//   o_frames_sent (wraps), o_underruns (saturates) - statistics
module mac_tx_ctrl #(
    parameter int N_HDR_WORDS   = 2,
    parameter int IFG_WORDS     = 3,
    parameter int W_MAC_HDR_CNT = (N_HDR_WORDS > 1) ? $clog2(N_HDR_WORDS) : 1,
    parameter int W_STAT        = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_clk_en,
    input  logic                     i_tx_en,
    input  logic                     i_frame_avail,
    input  logic                     i_buf_empty,
    input  logic                     i_buf_rlast,
    output logic                     o_buf_ren,
    output logic                     o_gen_hdr,
    output logic [W_MAC_HDR_CNT-1:0] o_hdr_id,
    output logic                     o_gen_data,
    output logic                     o_gen_error,
    output logic                     o_gen_idle,
    output logic                     o_gen_ifg,
    output logic                     o_frame_start,
    output logic                     o_busy,
    output logic [W_STAT-1:0]        o_frames_sent,
    output logic [W_STAT-1:0]        o_underruns
);

    localparam int W_GAP = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
    localparam logic [W_MAC_HDR_CNT-1:0] HDR_LAST = W_MAC_HDR_CNT'(N_HDR_WORDS - 1);
    localparam logic [W_GAP-1:0]         GAP_LAST = W_GAP'(IFG_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_FLUSH,
        ST_IFG
    } state_t;

    state_t                   state_q, state_d;
    logic [W_MAC_HDR_CNT-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [W_GAP-1:0]         gap_cnt_q, gap_cnt_d;
    logic [W_STAT-1:0]        frames_sent_q, frames_sent_d;
    logic [W_STAT-1:0]        underruns_q, underruns_d;

    logic start_ok;
    assign start_ok = i_tx_en & i_frame_avail;

    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frames_sent_d = frames_sent_q;
        underruns_d   = underruns_q;

        o_buf_ren     = 1'b0;
        o_gen_hdr     = 1'b0;
        o_hdr_id      = '0;
        o_gen_data    = 1'b0;
        o_gen_error   = 1'b0;
        o_gen_idle    = 1'b0;
        o_gen_ifg     = 1'b0;
        o_frame_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                o_gen_idle = 1'b1;
                if (start_ok) begin
                    state_d   = ST_HDR;
                    hdr_cnt_d = '0;
                end
            end
            ST_HDR: begin
                o_gen_hdr     = 1'b1;
                o_hdr_id      = hdr_cnt_q;
                o_frame_start = (hdr_cnt_q == '0);
                if (hdr_cnt_q == HDR_LAST) begin
                    state_d   = ST_DATA;
                    hdr_cnt_d = '0;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                // Empty dominates rlast: a stale last flag on an invalid head is ignored.
                if (!i_buf_empty) begin
                    o_gen_data = 1'b1;
                    o_buf_ren  = i_clk_en & i_reset_n;
                    if (i_buf_rlast) begin
                        frames_sent_d = frames_sent_q + 1'b1;
                        state_d       = ST_IFG;
                        gap_cnt_d     = '0;
                    end
                end else begin
                    o_gen_error = 1'b1;
                    if (underruns_q != '1) begin
                        underruns_d = underruns_q + 1'b1;
                    end
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Drain the rest of the broken frame up to and including its last word.
                o_gen_idle = 1'b1;
                o_buf_ren  = !i_buf_empty & i_clk_en & i_reset_n;
                if (!i_buf_empty && i_buf_rlast) begin
                    state_d   = ST_IFG;
                    gap_cnt_d = '0;
                end
            end
            ST_IFG: begin
                o_gen_ifg = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (start_ok) begin
                        state_d   = ST_HDR;
                        hdr_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                o_gen_idle = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_frames_sent = frames_sent_q;
    assign o_underruns   = underruns_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            hdr_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            frames_sent_q <= '0;
            underruns_q   <= '0;
        end else if (i_clk_en) begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frames_sent_q <= frames_sent_d;
            underruns_q   <= underruns_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_ctrl.sv
// Purpose: self-checking bench for mac_tx_ctrl against a frame-level behavioural model.
// Latency: checks each cycle at the falling edge, model advances at the rising edge.
// Backpressure: a queue-based FWFT buffer model reacts to o_buf_ren / o_frame_start.
module tb_mac_tx_ctrl;

    localparam int N_HDR    = 2;
    localparam int IFG      = 3;
    localparam int W_HDR    = 1;
    // Narrow statistics so that wrap and saturation are reachable in a short run.
    localparam int W_STAT   = 10;
    localparam int STAT_MAX = (1 << W_STAT) - 1;

    logic              clk = 1'b0;
    logic              i_reset_n, i_clk_en, i_tx_en, i_frame_avail, i_buf_empty, i_buf_rlast;
    logic              o_buf_ren, o_gen_hdr, o_gen_data, o_gen_error, o_gen_idle, o_gen_ifg;
    logic              o_frame_start, o_busy;
    logic [W_HDR-1:0]  o_hdr_id;
    logic [W_STAT-1:0] o_frames_sent, o_underruns;

    always #5 clk = ~clk;

    mac_tx_ctrl #(
        .N_HDR_WORDS  (N_HDR),
        .IFG_WORDS    (IFG),
        .W_MAC_HDR_CNT(W_HDR),
        .W_STAT       (W_STAT)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_clk_en     (i_clk_en),
        .i_tx_en      (i_tx_en),
        .i_frame_avail(i_frame_avail),
        .i_buf_empty  (i_buf_empty),
        .i_buf_rlast  (i_buf_rlast),
        .o_buf_ren    (o_buf_ren),
        .o_gen_hdr    (o_gen_hdr),
        .o_hdr_id     (o_hdr_id),
        .o_gen_data   (o_gen_data),
        .o_gen_error  (o_gen_error),
        .o_gen_idle   (o_gen_idle),
        .o_gen_ifg    (o_gen_ifg),
        .o_frame_start(o_frame_start),
        .o_busy       (o_busy),
        .o_frames_sent(o_frames_sent),
        .o_underruns  (o_underruns)
    );

    // Stimulus controls
    bit rst_n_i, clk_en_i, tx_en_i, stall_i, stall_mode;

    // Buffer model: one entry per buffered word, value = last-of-frame flag
    bit q_last[$];
    int pending;

    // Frame-level reference: words of header left, in data, flushing, gap words left
    int hdr_left, gap_left;
    bit in_data, flushing;
    int frames_m, unders_m;

    int    vectors, miscompares;
    string trace;
    int    fs_cnt, ren_cnt, ren_dis_cnt, busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic push_frame(input int len);
        for (int i = 0; i < len; i++) q_last.push_back(i == len - 1);
        pending++;
    endtask

    task automatic model_clear();
        hdr_left = 0; gap_left = 0; in_data = 0; flushing = 0;
        frames_m = 0; unders_m = 0;
        q_last.delete();
        pending = 0;
    endtask

    task automatic do_cycle();
        bit empty, rlast, avail;
        bit e_hdr, e_data, e_err, e_idle, e_ifg, e_ren, e_fs, e_busy;
        int e_id;
        string c;
        @(negedge clk);
        empty = (q_last.size() == 0) || stall_i || (stall_mode && in_data);
        rlast = (q_last.size() != 0) ? q_last[0] : 1'($urandom_range(0, 1));
        avail = (pending > 0);
        i_reset_n     = rst_n_i;
        i_clk_en      = clk_en_i;
        i_tx_en       = tx_en_i;
        i_frame_avail = avail;
        i_buf_empty   = empty;
        i_buf_rlast   = rlast;
        #1;
        {e_hdr, e_data, e_err, e_idle, e_ifg, e_ren, e_fs, e_busy} = '0;
        e_id = 0;
        if (hdr_left > 0) begin
            e_hdr = 1; e_id = N_HDR - hdr_left; e_fs = (hdr_left == N_HDR); e_busy = 1;
        end else if (in_data) begin
            e_busy = 1;
            if (!empty) begin e_data = 1; e_ren = clk_en_i & rst_n_i; end
            else e_err = 1;
        end else if (flushing) begin
            e_busy = 1; e_idle = 1; e_ren = !empty & clk_en_i & rst_n_i;
        end else if (gap_left > 0) begin
            e_busy = 1; e_ifg = 1;
        end else begin
            e_idle = 1;
        end
        check("gen_hdr", 32'(o_gen_hdr), 32'(e_hdr));
        check("hdr_id", 32'(o_hdr_id), 32'(e_id));
        check("gen_data", 32'(o_gen_data), 32'(e_data));
        check("gen_error", 32'(o_gen_error), 32'(e_err));
        check("gen_idle", 32'(o_gen_idle), 32'(e_idle));
        check("gen_ifg", 32'(o_gen_ifg), 32'(e_ifg));
        check("buf_ren", 32'(o_buf_ren), 32'(e_ren));
        check("frame_start", 32'(o_frame_start), 32'(e_fs));
        check("busy", 32'(o_busy), 32'(e_busy));
        check("frames_sent", 32'(o_frames_sent), 32'(frames_m));
        check("underruns", 32'(o_underruns), 32'(unders_m));
        if (clk_en_i) begin
            if (o_gen_hdr) c = "H";
            else if (o_gen_data) c = "D";
            else if (o_gen_error) c = "E";
            else if (o_gen_ifg) c = "G";
            else if (o_gen_idle) c = "I";
            else c = "?";
            trace = {trace, c};
        end
        if (o_frame_start && clk_en_i) fs_cnt++;
        if (o_buf_ren) ren_cnt++;
        if (o_buf_ren && !clk_en_i) ren_dis_cnt++;
        if (o_busy) busy_cnt++;
        @(posedge clk);
        if (!rst_n_i) begin
            model_clear();
        end else if (clk_en_i) begin
            if (e_ren) void'(q_last.pop_front());
            if (e_fs) pending--;
            if (hdr_left > 0) begin
                hdr_left--;
                if (hdr_left == 0) in_data = 1;
            end else if (in_data) begin
                in_data = 0;
                if (!empty) begin
                    if (rlast) begin
                        frames_m = (frames_m + 1) % (STAT_MAX + 1);
                        gap_left = IFG;
                    end else begin
                        in_data = 1;
                    end
                end else begin
                    if (unders_m < STAT_MAX) unders_m++;
                    flushing = 1;
                end
            end else if (flushing) begin
                if (!empty && rlast) begin flushing = 0; gap_left = IFG; end
            end else if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0 && tx_en_i && avail) hdr_left = N_HDR;
            end else if (tx_en_i && avail) begin
                hdr_left = N_HDR;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic clear_stats();
        trace = ""; fs_cnt = 0; ren_cnt = 0; ren_dis_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        model_clear();
        clear_stats();
        rst_n_i = 0; clk_en_i = 1; tx_en_i = 1; stall_i = 0; stall_mode = 0;
        i_reset_n = 0; i_clk_en = 1; i_tx_en = 0; i_frame_avail = 0;
        i_buf_empty = 1; i_buf_rlast = 0;
        @(posedge clk);

        // Reset state
        run(2);
        rst_n_i = 1;
        #1;
        check("rst_gen_idle", 32'(o_gen_idle), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_frames", 32'(o_frames_sent), 32'd0);

        // Single frame of 4 words
        clear_stats();
        push_frame(4);
        run(12);
        check_str("single_trace", trace, "IHHDDDDGGGII");
        check("single_frames", 32'(o_frames_sent), 32'd1);
        check("single_fs_pulses", 32'(fs_cnt), 32'd1);
        check("single_ren", 32'(ren_cnt), 32'd4);

        // Back-to-back frames
        clear_stats();
        push_frame(2);
        push_frame(2);
        run(16);
        check_str("b2b_trace", trace, "IHHDDGGGHHDDGGGI");
        check("b2b_frames", 32'(o_frames_sent), 32'd3);

        // Underrun after 2 data words, then 3 remaining words flushed
        clear_stats();
        push_frame(5);
        run(5);
        stall_i = 1;
        run(1);
        stall_i = 0;
        run(7);
        check_str("under_trace", trace, "IHHDDEIIIGGGI");
        check("under_count", 32'(o_underruns), 32'd1);
        check("under_frames", 32'(o_frames_sent), 32'd3);
        check("under_ren", 32'(ren_cnt), 32'd5);

        // Clock enable toggling
        clear_stats();
        push_frame(4);
        for (int i = 0; i < 24; i++) begin
            clk_en_i = (i % 2 == 0);
            do_cycle();
        end
        clk_en_i = 1;
        check_str("clken_trace", trace, "IHHDDDDGGGII");
        check("clken_ren_disabled", 32'(ren_dis_cnt), 32'd0);
        check("clken_frames", 32'(o_frames_sent), 32'd4);

        // Reset in DATA
        push_frame(4);
        run(4);
        rst_n_i = 0;
        run(1);
        rst_n_i = 1;
        #1;
        check("rstdata_gen_idle", 32'(o_gen_idle), 32'd1);
        check("rstdata_gen_data", 32'(o_gen_data), 32'd0);
        check("rstdata_busy", 32'(o_busy), 32'd0);
        check("rstdata_frames", 32'(o_frames_sent), 32'd0);
        check("rstdata_underruns", 32'(o_underruns), 32'd0);

        // tx_en low with a frame available
        clear_stats();
        tx_en_i = 0;
        push_frame(3);
        run(10);
        check("txoff_ren", 32'(ren_cnt), 32'd0);
        check("txoff_busy", 32'(busy_cnt), 32'd0);
        tx_en_i = 1;
        run(12);
        check("txoff_drain_frames", 32'(o_frames_sent), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            clk_en_i = ($urandom_range(0, 3) != 0);
            tx_en_i  = ($urandom_range(0, 9) != 0);
            stall_i  = ($urandom_range(0, 6) == 0);
            rst_n_i  = ($urandom_range(0, 399) != 0);
            if (pending < 3 && $urandom_range(0, 3) == 0) push_frame($urandom_range(1, 6));
            do_cycle();
        end
        clk_en_i = 1; tx_en_i = 1; stall_i = 0;

        // Underrun saturation
        rst_n_i = 0;
        run(2);
        rst_n_i = 1;
        stall_mode = 1;
        for (int k = 0; k < STAT_MAX + 2; k++) push_frame(1);
        run((STAT_MAX + 2) * 7 + 10);
        check("sat_underruns", 32'(o_underruns), 32'(STAT_MAX));
        check("sat_frames", 32'(o_frames_sent), 32'd0);
        stall_mode = 0;

        // Frame counter wrap
        rst_n_i = 0;
        run(2);
        rst_n_i = 1;
        clear_stats();
        for (int k = 0; k < STAT_MAX + 1; k++) push_frame(1);
        run((STAT_MAX + 1) * 6 + 10);
        check("wrap_frames", 32'(o_frames_sent), 32'd0);
        check("wrap_ren", 32'(ren_cnt), 32'(STAT_MAX + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
